// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: shifts one bit-plane per row pass, latches it, then lights
// the row for OE_BASE<<plane cycles (binary-coded modulation).
module hub75_scan_driver #(
  parameter int WIDTH    = 64,
  parameter int ROW_BITS = 5,
  parameter int BITS     = 8,
  parameter int OE_BASE  = 4
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                enable,
  output logic [ROW_BITS+$clog2(WIDTH)-1:0]   rd_addr,
  input  logic [6*BITS-1:0]                   rd_data,
  output logic                                pclk,
  output logic                                r0,
  output logic                                g0,
  output logic                                b0,
  output logic                                r1,
  output logic                                g1,
  output logic                                b1,
  output logic [ROW_BITS-1:0]                 addr,
  output logic                                lat,
  output logic                                oe_n,
  output logic                                frame_done
);
  localparam int CB = $clog2(WIDTH);
  localparam int PB = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int CW = $clog2(OE_BASE) + BITS;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t              r_state, w_state;
  logic [1:0]          r_phase, w_phase;
  logic [CB-1:0]       r_col, w_col;
  logic [ROW_BITS-1:0] r_row, w_row;
  logic [PB-1:0]       r_plane, w_plane;
  logic [CW-1:0]       r_cnt, w_cnt;

  logic [CW-1:0]       w_dur;
  logic                w_disp_last, w_last_plane, w_last_row;

  logic                      r_pclk, r_lat, r_oe_n, r_fd;
  logic [ROW_BITS-1:0]       r_addr;
  logic [ROW_BITS+CB-1:0]    r_rd_addr;
  logic [5:0]                r_pins;
  logic                      w_pclk_d, w_lat_d, w_oe_n_d, w_fd_d;
  logic [ROW_BITS-1:0]       w_addr_d;
  logic [ROW_BITS+CB-1:0]    w_rd_addr_d;
  logic [5:0]                w_pins_d, w_bits;
  logic [BITS-1:0]           w_slice;

  assign w_dur        = CW'(OE_BASE) << r_plane;
  assign w_disp_last  = (r_cnt == w_dur - CW'(1));
  assign w_last_plane = (r_plane == PB'(BITS-1));
  assign w_last_row   = &r_row;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_col   <= '0;
      r_row   <= '0;
      r_plane <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_col   <= w_col;
      r_row   <= w_row;
      r_plane <= w_plane;
      r_cnt   <= w_cnt;
    end
  end

  // r_phase doubles as the LATCH cycle index (0 = strobe, 1 = release)
  always_comb begin
    w_state = r_state;
    w_phase = r_phase;
    w_col   = r_col;
    w_row   = r_row;
    w_plane = r_plane;
    w_cnt   = r_cnt;
    case (r_state)
      IDLE: if (enable) begin
        w_state = SHIFT;
        w_phase = '0;
        w_col   = '0;
      end
      SHIFT: if (r_phase == 2'd2) begin
        w_phase = '0;
        if (r_col == CB'(WIDTH-1)) begin
          w_state = LATCH;
          w_col   = '0;
        end else begin
          w_col = r_col + CB'(1);
        end
      end else begin
        w_phase = r_phase + 2'd1;
      end
      LATCH: if (r_phase == 2'd0) begin
        w_phase = 2'd1;
      end else begin
        w_state = DISPLAY;
        w_phase = '0;
        w_cnt   = '0;
      end
      DISPLAY: if (w_disp_last) begin
        w_cnt = '0;
        if (w_last_plane) begin
          w_plane = '0;
          w_row   = r_row + ROW_BITS'(1);
        end else begin
          w_plane = r_plane + PB'(1);
        end
        w_state = enable ? SHIFT : IDLE;
      end else begin
        w_cnt = r_cnt + CW'(1);
      end
      default: w_state = IDLE;
    endcase
  end

  always_comb begin
    w_bits  = '0;
    w_slice = '0;
    for (int i = 0; i < 6; i++) begin
      w_slice   = rd_data[i*BITS +: BITS];
      w_bits[i] = w_slice[r_plane];
    end
  end

  // Output values are derived from the next state so registered pins line up
  // with the state they describe.
  always_comb begin
    w_pclk_d    = (w_state == SHIFT) && (w_phase == 2'd2);
    w_lat_d     = (w_state == LATCH) && (w_phase == 2'd0);
    w_oe_n_d    = (w_state != DISPLAY);
    w_addr_d    = r_addr;
    if (w_lat_d) w_addr_d = w_row;
    w_rd_addr_d = r_rd_addr;
    if ((w_state == SHIFT) && (w_phase == 2'd0)) w_rd_addr_d = {w_row, w_col};
    w_pins_d    = r_pins;
    if ((r_state == SHIFT) && (r_phase == 2'd1)) w_pins_d = w_bits;
    else if (w_state == IDLE)                    w_pins_d = '0;
    w_fd_d      = (w_state == DISPLAY) && (w_cnt == w_dur - CW'(1)) &&
                  w_last_plane && w_last_row;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pclk    <= 1'b0;
      r_lat     <= 1'b0;
      r_oe_n    <= 1'b1;
      r_fd      <= 1'b0;
      r_addr    <= '0;
      r_rd_addr <= '0;
      r_pins    <= '0;
    end else begin
      r_pclk    <= w_pclk_d;
      r_lat     <= w_lat_d;
      r_oe_n    <= w_oe_n_d;
      r_fd      <= w_fd_d;
      r_addr    <= w_addr_d;
      r_rd_addr <= w_rd_addr_d;
      r_pins    <= w_pins_d;
    end
  end

  assign pclk       = r_pclk;
  assign lat        = r_lat;
  assign oe_n       = r_oe_n;
  assign frame_done = r_fd;
  assign addr       = r_addr;
  assign rd_addr    = r_rd_addr;
  assign {r0, g0, b0, r1, g1, b1} = r_pins;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench: stimulus pushes expected shifts, latches, display lengths and
// frame pulses; a negedge monitor pops and compares as the panel pins show them.
module tb_hub75_scan_driver;
  logic clock = 1'b0;
  logic reset_n, enable, enable_b;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic pclk, r0, g0, b0, r1, g1, b1, lat, oe_n, frame_done;
  logic [0:0]  addr;
  logic [10:0] rd_addr_b;
  logic [47:0] rd_data_b = '0;
  logic pclk_b, r0_b, g0_b, b0_b, r1_b, g1_b, b1_b, lat_b, oe_n_b, fd_b;
  logic [4:0]  addr_b;

  always #5 clock = ~clock;

  hub75_scan_driver #(.WIDTH(4), .ROW_BITS(1), .BITS(2), .OE_BASE(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .rd_addr(rd_addr),
    .rd_data(rd_data), .pclk(pclk), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1),
    .b1(b1), .addr(addr), .lat(lat), .oe_n(oe_n), .frame_done(frame_done));

  hub75_scan_driver #(.WIDTH(64), .ROW_BITS(5), .BITS(8), .OE_BASE(4)) dut_big (
    .clock(clock), .reset_n(reset_n), .enable(enable_b), .rd_addr(rd_addr_b),
    .rd_data(rd_data_b), .pclk(pclk_b), .r0(r0_b), .g0(g0_b), .b0(b0_b), .r1(r1_b),
    .g1(g1_b), .b1(b1_b), .addr(addr_b), .lat(lat_b), .oe_n(oe_n_b), .frame_done(fd_b));

  // Buffer model: one-cycle read latency
  logic [11:0] mem [8];
  always @(posedge clock) rd_data <= mem[rd_addr];

  typedef struct packed { logic [5:0] pins; logic [2:0] ra; } pix_t;
  typedef struct packed { logic a; int gap; } lat_t;
  pix_t q_pix[$];
  lat_t q_lat[$];
  int   q_oe[$];
  int   q_fd[$];
  int   q_big[$];

  // Hand-computed bit per column (bit c = column c) for r0 and b1, per plane
  logic [3:0] exp_r0 [2];
  logic [3:0] exp_b1 [2];
  logic [1:0] r0v [4];
  logic [1:0] b1v [4];

  int checks = 0, errors = 0;
  int pclk_total = 0, fd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_pass(input int row, input int plane, input int gap, input bit oe);
    pix_t p;
    lat_t l;
    for (int c = 0; c < 4; c++) begin
      p.pins = {exp_r0[plane][c], 3'b000, row[0], exp_b1[plane][c]};
      p.ra   = 3'(row*4 + c);
      q_pix.push_back(p);
    end
    l.a   = row[0];
    l.gap = gap;
    q_lat.push_back(l);
    if (oe) q_oe.push_back(2 << plane);
  endtask

  // Monitor
  logic pp, in_run, in_run_b;
  logic [0:0] run_addr;
  int run_len, addr_moves, pclk_cnt, since_lat, since_fd, run_b;
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        pp = 0; in_run = 0; run_len = 0; addr_moves = 0; pclk_cnt = 0;
        since_lat = 0; since_fd = 0; in_run_b = 0; run_b = 0;
      end else begin
        since_lat++;
        since_fd++;
        if (pclk && !pp) begin
          pix_t e;
          pclk_cnt++;
          pclk_total++;
          if (q_pix.size() == 0) chk("pix_unexpected", 32'(q_pix.size()), 1);
          else begin
            e = q_pix.pop_front();
            chk("pins", 32'({r0, g0, b0, r1, g1, b1}), 32'(e.pins));
            chk("rd_addr", 32'(rd_addr), 32'(e.ra));
          end
        end
        pp = pclk;
        if (lat) begin
          lat_t e;
          chk("shift_cols", 32'(pclk_cnt), 4);
          pclk_cnt = 0;
          if (q_lat.size() == 0) chk("lat_unexpected", 32'(q_lat.size()), 1);
          else begin
            e = q_lat.pop_front();
            chk("lat_addr", 32'(addr), 32'(e.a));
            if (e.gap >= 0) chk("plane_cycles", 32'(since_lat), 32'(e.gap));
          end
          since_lat = 0;
        end
        if (!oe_n) begin
          if (!in_run) begin in_run = 1; run_len = 0; addr_moves = 0; run_addr = addr; end
          run_len++;
          if (addr !== run_addr) addr_moves++;
        end else if (in_run) begin
          in_run = 0;
          if (q_oe.size() == 0) chk("oe_unexpected", 32'(q_oe.size()), 1);
          else chk("oe_low_cycles", 32'(run_len), 32'(q_oe.pop_front()));
          chk("addr_stable", 32'(addr_moves), 0);
        end
        if (frame_done) begin
          int e;
          fd_cnt++;
          chk("fd_oe_low", 32'(oe_n), 0);
          chk("fd_addr", 32'(addr), 1);
          chk("fd_last_disp", 32'(since_lat), 5);
          if (q_fd.size() == 0) chk("fd_unexpected", 32'(q_fd.size()), 1);
          else begin
            e = q_fd.pop_front();
            if (e >= 0) chk("frame_gap", 32'(since_fd), 32'(e));
          end
          since_fd = 0;
        end
        if (!oe_n_b) begin
          in_run_b = 1;
          run_b++;
        end else if (in_run_b) begin
          in_run_b = 0;
          if (q_big.size() != 0) chk("big_oe_low", 32'(run_b), 32'(q_big.pop_front()));
          run_b = 0;
        end
      end
    end
  end

  task automatic idle_check(input string name);
    int p0;
    p0 = pclk_total;
    repeat (20) @(negedge clock);
    chk(name, 32'(pclk_total), 32'(p0));
    chk({name, "_oe_n"}, 32'(oe_n), 1);
  endtask

  initial begin
    exp_r0[0] = 4'b0101; exp_r0[1] = 4'b0110;
    exp_b1[0] = 4'b1001; exp_b1[1] = 4'b0101;
    r0v = '{2'b01, 2'b10, 2'b11, 2'b00};
    b1v = '{2'b11, 2'b00, 2'b10, 2'b01};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        mem[r*4 + c] = {r0v[c], 2'b00, 2'b00, 2'b00, (r == 1) ? 2'b11 : 2'b00, b1v[c]};

    enable = 0; enable_b = 0; reset_n = 1;
    #2 reset_n = 0;
    #1;
    chk("rst_oe_n", 32'(oe_n), 1);
    chk("rst_pclk", 32'(pclk), 0);
    chk("rst_lat", 32'(lat), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_pins", 32'({r0, g0, b0, r1, g1, b1}), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    repeat (3) @(negedge clock);
    reset_n = 1;
    idle_check("idle_after_reset");

    // Two continuous frames, then a pass that loses enable mid-shift
    push_pass(0, 0, -1, 1); push_pass(0, 1, 16, 1); push_pass(1, 0, 18, 1); push_pass(1, 1, 16, 1);
    push_pass(0, 0, 18, 1); push_pass(0, 1, 16, 1); push_pass(1, 0, 18, 1); push_pass(1, 1, 16, 1);
    push_pass(0, 0, 18, 1);
    q_fd.push_back(-1); q_fd.push_back(68);
    enable = 1;
    for (int i = 0; i < 300 && fd_cnt < 2; i++) begin @(negedge clock); #1; end
    chk("two_frames_seen", 32'(fd_cnt), 2);
    repeat (5) @(negedge clock);
    enable = 0;
    repeat (40) @(negedge clock);
    chk("drop_pass_drained", 32'(q_oe.size() + q_lat.size() + q_pix.size()), 0);
    idle_check("idle_after_drop");

    // Resume picks up the next plane of the same row
    push_pass(0, 1, -1, 1);
    enable = 1;
    repeat (5) @(negedge clock);
    enable = 0;
    repeat (40) @(negedge clock);
    chk("resume_drained", 32'(q_oe.size() + q_lat.size() + q_pix.size()), 0);

    // Asynchronous reset in the middle of DISPLAY
    push_pass(1, 0, -1, 0);
    enable = 1;
    repeat (3) @(negedge clock);
    enable = 0;
    for (int i = 0; i < 60 && oe_n !== 1'b0; i++) @(negedge clock);
    chk("reached_display", 32'(oe_n), 0);
    #2 reset_n = 0;
    #1;
    chk("async_oe_n", 32'(oe_n), 1);
    chk("async_lat", 32'(lat), 0);
    chk("async_pclk", 32'(pclk), 0);
    chk("async_addr", 32'(addr), 0);
    @(negedge clock);
    reset_n = 1;
    idle_check("idle_after_async_reset");
    push_pass(0, 0, -1, 1);
    enable = 1;
    repeat (5) @(negedge clock);
    enable = 0;
    repeat (40) @(negedge clock);
    chk("post_reset_drained", 32'(q_oe.size() + q_lat.size() + q_pix.size()), 0);
    chk("frame_pulses", 32'(fd_cnt), 2);

    // Full-size instance: plane 7 must hold oe_n low for 512 cycles
    for (int p = 0; p < 8; p++) q_big.push_back(4 << p);
    enable_b = 1;
    for (int i = 0; i < 4000 && q_big.size() != 0; i++) @(negedge clock);
    chk("big_planes_done", 32'(q_big.size()), 0);
    enable_b = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
